// File: rtl/vert_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vert_sweep_ctrl_if
// Description : Signal bundle between the vertical sweep controller and its
//               surroundings (sweep request, limit counter, light comparator,
//               servo step commands and status).
// Revision    : 1.0 - initial release
// ============================================================================
interface vert_sweep_ctrl_if #(
    parameter int POS_W = 4
);
    logic             start;
    logic             cnt_d;
    logic             light_gt;
    logic             vs;
    logic             servo_up;
    logic             servo_dn;
    logic [POS_W-1:0] best_pos;
    logic             busy;
    logic             done;
    logic             err;

    // Environment side: issues requests and returns counter/comparator status
    modport master (
        output start, cnt_d, light_gt,
        input  vs, servo_up, servo_dn, best_pos, busy, done, err
    );

    // Controller side
    modport slave (
        input  start, cnt_d, light_gt,
        output vs, servo_up, servo_dn, best_pos, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/vert_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vert_sweep_ctrl
// Description : Vertical calibration sweep controller. Steps the servo up
//               while the limit counter reports in-range, remembers the
//               position of the brightest reading, then steps back down to
//               it. All outputs are registered.
//               Optional macro VSWEEP_TIMEOUT_EN adds a watchdog on the ARM
//               and SWEEP states that aborts to IDLE via TOUT and raises ERR.
// Revision    : 1.0 - initial release
// ============================================================================
module vert_sweep_ctrl #(
    parameter int POS_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    vert_sweep_ctrl_if.slave  bus
);

`ifdef VSWEEP_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SWEEP  = 3'd2,
        ST_RETURN = 3'd3,
        ST_FIN    = 3'd4,
        ST_TOUT   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_SWEEP  = 3'd2,
        ST_RETURN = 3'd3,
        ST_FIN    = 3'd4
    } state_t;
`endif

    localparam logic [POS_W-1:0] POS_MAX = '1;

    // A watchdog limit below one cycle is meaningless
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("vert_sweep_ctrl: TIMEOUT must be at least 1");
    end

    state_t           state, state_nx;
    logic [POS_W-1:0] pos, pos_nx;
    logic [POS_W-1:0] best, best_nx;
    logic             vs, vs_nx;
    logic             up, up_nx;
    logic             dn, dn_nx;
    logic             busy, busy_nx;
    logic             done, done_nx;

`ifdef VSWEEP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] wd, wd_nx;
    logic            err, err_nx;
    logic            wd_hit;

    assign wd_hit = (wd == WD_LAST);
`endif

    // Next-state and next-output computation; outputs follow the next state
    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        best_nx  = best;
        up_nx    = 1'b0;
        dn_nx    = 1'b0;
`ifdef VSWEEP_TIMEOUT_EN
        err_nx   = err;
        wd_nx    = wd + WD_W'(1);
`endif
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx = ST_ARM;
                    pos_nx   = '0;
                    best_nx  = '0;
`ifdef VSWEEP_TIMEOUT_EN
                    err_nx   = 1'b0;
`endif
                end
            end
            ST_ARM: begin
`ifdef VSWEEP_TIMEOUT_EN
                if (wd_hit) begin
                    state_nx = ST_TOUT;
                end else
`endif
                if (bus.cnt_d) begin
                    state_nx = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
`ifdef VSWEEP_TIMEOUT_EN
                if (wd_hit) begin
                    state_nx = ST_TOUT;
                end else
`endif
                if (bus.cnt_d) begin
                    // Record the pre-step position; later hits overwrite
                    if (bus.light_gt) begin
                        best_nx = pos;
                    end
                    // Saturate at the top instead of wrapping
                    if (pos != POS_MAX) begin
                        up_nx  = 1'b1;
                        pos_nx = pos + POS_W'(1);
                    end
                end else begin
                    state_nx = ST_RETURN;
                end
            end
            ST_RETURN: begin
                if (pos != best) begin
                    dn_nx  = 1'b1;
                    pos_nx = pos - POS_W'(1);
                end else begin
                    state_nx = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nx = ST_IDLE;
            end
`ifdef VSWEEP_TIMEOUT_EN
            ST_TOUT: begin
                state_nx = ST_IDLE;
            end
`endif
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

`ifdef VSWEEP_TIMEOUT_EN
        // Restart the watchdog whenever a new state is entered
        if (state_nx != state) begin
            wd_nx = '0;
        end
        if (state_nx == ST_TOUT) begin
            err_nx = 1'b1;
        end
`endif

        vs_nx   = (state_nx == ST_ARM) || (state_nx == ST_SWEEP);
        busy_nx = (state_nx != ST_IDLE);
        done_nx = (state_nx == ST_FIN);
    end

    // State, position and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pos   <= '0;
            best  <= '0;
            vs    <= 1'b0;
            up    <= 1'b0;
            dn    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            pos   <= pos_nx;
            best  <= best_nx;
            vs    <= vs_nx;
            up    <= up_nx;
            dn    <= dn_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

`ifdef VSWEEP_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd  <= wd_nx;
            err <= err_nx;
        end
    end

    assign bus.err = err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.vs       = vs;
    assign bus.servo_up = up;
    assign bus.servo_dn = dn;
    assign bus.best_pos = best;
    assign bus.busy     = busy;
    assign bus.done     = done;

endmodule
`default_nettype wire

// File: tb/tb_vert_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vert_sweep_ctrl
// Description : Directed scoreboard bench for vert_sweep_ctrl. Each accepted
//               sweep pushes its expected step counts and best position; a
//               negedge monitor tallies servo pulses and checks them on DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vert_sweep_ctrl;

    typedef struct {
        int         ups;
        int         dns;
        logic [3:0] best;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   accepted;
    int   done_seen;
    int   cur_ups;
    int   cur_dns;
    exp_t sbq[$];

    vert_sweep_ctrl_if #(.POS_W(4)) bus ();

    vert_sweep_ctrl #(
        .POS_W   (4),
        .TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: count servo pulses, score each DONE against the queue
    always @(negedge clk) begin
        if (rst) begin
            cur_ups = 0;
            cur_dns = 0;
        end else begin
            if (bus.servo_up && bus.servo_dn) begin
                chk("servo_exclusive", 1, 0);
            end
            if (bus.servo_up) cur_ups++;
            if (bus.servo_dn) cur_dns++;
            if (bus.done) begin
                done_seen++;
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("servo_up_count", cur_ups, e.ups);
                    chk("servo_dn_count", cur_dns, e.dns);
                    chk("best_pos", int'(bus.best_pos), int'(e.best));
                    chk("vs_at_done", int'(bus.vs), 0);
                    chk("busy_at_done", int'(bus.busy), 1);
                end
                cur_ups = 0;
                cur_dns = 0;
            end
        end
    end

    // One sweep: caller is just after a posedge with the DUT idle
    task automatic run_sweep(input int arm_wait, input int n_high,
                             input logic [31:0] mask, input bit pulse,
                             input int e_ups, input int e_dns,
                             input logic [3:0] e_best);
        exp_t e;
        int   c;
        e.ups  = e_ups;
        e.dns  = e_dns;
        e.best = e_best;
        sbq.push_back(e);
        accepted++;
        bus.start    = 1'b1;
        bus.cnt_d    = 1'b0;
        bus.light_gt = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (arm_wait) begin
            @(posedge clk); #1;
        end
        bus.cnt_d = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < n_high; k++) begin
            bus.cnt_d    = 1'b1;
            bus.light_gt = mask[k];
            bus.start    = pulse && (k == 4);
            @(posedge clk); #1;
        end
        bus.cnt_d    = 1'b0;
        bus.light_gt = 1'b0;
        bus.start    = 1'b0;
        c = 0;
        while (bus.busy && c < 100) begin
            bus.start = pulse && (c == 3);
            @(posedge clk); #1;
            c++;
        end
        bus.start = 1'b0;
        if (bus.busy) begin
            chk("sweep_timeout", 1, 0);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vs"},       int'(bus.vs),       0);
        chk({tag, "_servo_up"}, int'(bus.servo_up), 0);
        chk({tag, "_servo_dn"}, int'(bus.servo_dn), 0);
        chk({tag, "_busy"},     int'(bus.busy),     0);
        chk({tag, "_done"},     int'(bus.done),     0);
        chk({tag, "_err"},      int'(bus.err),      0);
        chk({tag, "_best_pos"}, int'(bus.best_pos), 0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        accepted  = 0;
        done_seen = 0;
        cur_ups   = 0;
        cur_dns   = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.cnt_d    = 1'b0;
        bus.light_gt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Full 15-step sweep, no light: back down to 0
        run_sweep(0, 15, 32'h0000_0000, 1'b0, 15, 15, 4'd0);
        // Single hit at POS=6
        run_sweep(2, 15, 32'h0000_0040, 1'b0, 15, 9, 4'd6);
        // Hit on the last in-range cycle (POS=14)
        run_sweep(0, 15, 32'h0000_4000, 1'b0, 15, 1, 4'd14);
        // Two hits: the later one (POS=9) wins
        run_sweep(1, 15, 32'h0000_0208, 1'b0, 15, 6, 4'd9);
        // Over-long range: POS saturates at 15, hit while saturated -> no return steps
        run_sweep(0, 20, 32'h0004_0000, 1'b0, 15, 0, 4'd15);
        // Range ends immediately after ARM
        run_sweep(0, 0, 32'h0000_0000, 1'b0, 0, 0, 4'd0);
        // Short sweep with a hit at POS=1
        run_sweep(0, 3, 32'h0000_0002, 1'b0, 3, 2, 4'd1);
        // START pulses during SWEEP and RETURN are ignored
        run_sweep(0, 15, 32'h0000_0000, 1'b1, 15, 15, 4'd0);

        // Reset in the middle of a sweep at POS=5, with START also high
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.cnt_d = 1'b1;
        @(posedge clk); #1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("mid_sweep_busy", int'(bus.busy), 1);
        chk("mid_sweep_vs",   int'(bus.vs),   1);
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        check_all_zero("abort");
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.cnt_d = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle_busy", int'(bus.busy), 0);

        // Fresh sweep after the abort
        run_sweep(0, 15, 32'h0000_0800, 1'b0, 15, 4, 4'd11);

        // Limit counter never ready: without the watchdog ARM waits forever
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (100) begin
            @(posedge clk); #1;
        end
        chk("stuck_busy",     int'(bus.busy),     1);
        chk("stuck_vs",       int'(bus.vs),       1);
        chk("stuck_err",      int'(bus.err),      0);
        chk("stuck_servo_up", int'(bus.servo_up), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("recover_busy", int'(bus.busy), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sbq.size(), 0);
        chk("done_count", done_seen, accepted);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/vert_sweep_ctrl.md
VERT_SWEEP_CTRL -- requirements
Module: vert_sweep_ctrl

Interface
REQ-001 Parameter POS_W, default 4, width of the position counter and BEST_POS.
REQ-002 Parameter TIMEOUT, default 64, watchdog limit in CLK cycles (used only with VSWEEP_TIMEOUT_EN).
REQ-003 CLK  in  1  system clock; all logic on its rising edge; single clock domain.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 START  in  1  request one vertical calibration sweep; sampled in IDLE only.
REQ-006 CNT_D  in  1  counter-down enable returned by the vertical limit counter; 1 = within sweep range.
REQ-007 LIGHT_GT  in  1  comparator: current light reading exceeds the stored maximum.
REQ-008 VS  out  1  vertical sweep enable to the limit counter.
REQ-009 SERVO_UP  out  1  one-step up command, one per cycle while asserted.
REQ-010 SERVO_DN  out  1  one-step down command, one per cycle while asserted.
REQ-011 BEST_POS  out  POS_W  position of maximum light found in the last sweep.
REQ-012 BUSY  out  1  high in every state except IDLE.
REQ-013 DONE  out  1  one-cycle pulse on sweep completion.
REQ-014 ERR  out  1  sticky watchdog flag; cleared by RST or next accepted START.

Function
REQ-015 States SHALL be IDLE, ARM, SWEEP, RETURN, FIN (plus TOUT with the macro); all outputs registered.
REQ-016 IDLE: VS=0, servo outputs 0; START=1 -> ARM next cycle, POS and BEST_POS cleared to 0.
REQ-017 ARM: VS=1; CNT_D=1 -> SWEEP; CNT_D=0 -> remain.
REQ-018 SWEEP: VS=1; each cycle with CNT_D=1: SERVO_UP=1, POS<=POS+1.
REQ-019 POS SHALL saturate at 2^POS_W-1, no wrap; SERVO_UP=0 while saturated.
REQ-020 SWEEP, CNT_D=1 and LIGHT_GT=1: BEST_POS<=POS (pre-increment value); latest qualifying sample wins.
REQ-021 SWEEP, CNT_D=0: VS<=0 next cycle, -> RETURN; no step issued that cycle.
REQ-022 RETURN: VS=0; POS!=BEST_POS -> SERVO_DN=1, POS<=POS-1; POS==BEST_POS -> FIN, no step.
REQ-023 Sweep ending with POS==BEST_POS SHALL pass through RETURN in one cycle with no SERVO_DN.
REQ-024 FIN: DONE=1 for exactly one cycle, -> IDLE; BEST_POS held until next accepted START.
REQ-025 START outside IDLE SHALL be ignored; START held high re-arms only after FIN returns to IDLE.
REQ-026 SERVO_UP and SERVO_DN SHALL never be high in the same cycle.

Reset
REQ-027 RST=1 SHALL force IDLE next edge: VS, SERVO_UP, SERVO_DN, BUSY, DONE, ERR = 0; POS, BEST_POS = 0.
REQ-028 RST mid-sweep SHALL abort without DONE; RST dominates START in the same cycle.

Configuration
REQ-029 Macro VSWEEP_TIMEOUT_EN defined: watchdog counts cycles in ARM and SWEEP, cleared on each state entry; reaching TIMEOUT -> TOUT: VS=0, ERR=1, one cycle, then IDLE, no DONE.
REQ-030 Macro undefined: no watchdog logic, ARM/SWEEP wait indefinitely, ERR tied 0, TOUT absent.

Verification
REQ-031 START with 4-bit limit counter (CNT_D high 15 cycles), LIGHT_GT=0 -> 15 SERVO_UP, BEST_POS=0, 15 SERVO_DN, DONE once, VS low after.
REQ-032 LIGHT_GT=1 only while POS=6 -> BEST_POS=6, 15 SERVO_UP then 9 SERVO_DN, DONE once.
REQ-033 LIGHT_GT=1 on last CNT_D cycle (POS=14) -> BEST_POS=14, 1 SERVO_DN.
REQ-034 RST asserted in SWEEP at POS=5 -> next cycle IDLE, all outputs 0, no DONE; fresh START runs normally.
REQ-035 CNT_D tied 0 with VSWEEP_TIMEOUT_EN, TIMEOUT=64 -> ERR=1 after 64 ARM cycles, VS=0, no DONE; without macro BUSY stays 1.
REQ-036 START pulsed during SWEEP and RETURN -> ignored; exactly one DONE per accepted START.
